// File: rtl/hazard_stall_unit.sv
// ID-stage interlock. Compares the ID instruction's sources (rs/rt, HI, LO)
// against pending writes in the N_STG later stages and holds IF/ID for as
// many cycles as the nearest producer needs. State updates on the falling
// edge so a stall raised mid-cycle already gates the following rising edge.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RUN   | no stall; each falling edge evaluates the ID instruction
//   ST_STALL | stall held; stall_left counts down, inputs other than
//            | flush are ignored
module hazard_stall_unit #(
  parameter  int AW     = 5,
  parameter  int N_STG  = 2,
  parameter  int FWD_EN = 0,
  parameter  int PERF_W = 16,
  localparam int CW     = $clog2(N_STG + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [AW-1:0]       id_rs,
  input  logic [AW-1:0]       id_rt,
  input  logic                id_rs_rd,
  input  logic                id_rt_rd,
  input  logic                id_hi_rd,
  input  logic                id_lo_rd,
  input  logic [N_STG*AW-1:0] stg_waddr,
  input  logic [N_STG-1:0]    stg_rf_we,
  input  logic [N_STG-1:0]    stg_hi_we,
  input  logic [N_STG-1:0]    stg_lo_we,
  input  logic [N_STG-1:0]    stg_is_load,
  input  logic                flush,
  output logic                stall,
  output logic [CW-1:0]       stall_left,
  output logic [PERF_W-1:0]   hazard_cnt
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              stall_q, stall_d;
  logic [CW-1:0]     left_q, left_d;
  logic [PERF_W-1:0] cnt_q, cnt_d;

  logic [N_STG-1:0]  gpr_hit;
  logic [N_STG-1:0]  hilo_hit;
  logic [CW-1:0]     req_len;

  // Depending on FWD_EN some per-stage inputs are never consulted.
  logic unused_inputs;
  assign unused_inputs = ^{stg_is_load, stg_hi_we, stg_lo_we};

  // Per-stage source matches; writes to $0 never create a hazard.
  always_comb begin
    gpr_hit  = '0;
    hilo_hit = '0;
    for (int k = 0; k < N_STG; k++) begin
      gpr_hit[k] = stg_rf_we[k] &
                   ((id_rs_rd && (id_rs != '0) && (stg_waddr[k*AW +: AW] == id_rs)) ||
                    (id_rt_rd && (id_rt != '0) && (stg_waddr[k*AW +: AW] == id_rt)));
      hilo_hit[k] = (id_hi_rd & stg_hi_we[k]) | (id_lo_rd & stg_lo_we[k]);
    end
  end

  // Required stall length: nearest producer dominates, or load-use only
  // when results are forwarded (HI/LO is forwarded in that mode too).
  always_comb begin
    req_len = '0;
    if (FWD_EN != 0) begin
      if (gpr_hit[0] && stg_is_load[0]) req_len = CW'(1);
    end else begin
      for (int k = N_STG - 1; k >= 0; k--) begin
        if (gpr_hit[k] || hilo_hit[k]) req_len = CW'(N_STG - k);
      end
    end
  end

  // Next-state: flush wins, then detection in RUN, then countdown in STALL.
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    left_d  = left_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_RUN;
      stall_d = 1'b0;
      left_d  = '0;
    end else if (state_q == ST_RUN) begin
      if (id_valid && (req_len != '0)) begin
        state_d = ST_STALL;
        stall_d = 1'b1;
        left_d  = req_len - CW'(1);
        cnt_d   = cnt_q + PERF_W'(1);
      end
    end else if (left_q != '0) begin
      left_d = left_q - CW'(1);
    end else begin
      state_d = ST_RUN;
      stall_d = 1'b0;
    end
  end

  // State registers on the falling edge, async active-high reset.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      stall_q <= 1'b0;
      left_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall      = stall_q;
  assign stall_left = left_q;
  assign hazard_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: a default full-stall instance and a forwarding instance
// (N_STG=3, 2-bit event counter so wrap-around is reachable quickly).
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst, rst_fwd;
  logic        id_valid, id_rs_rd, id_rt_rd, id_hi_rd, id_lo_rd, flush;
  logic [4:0]  id_rs, id_rt;

  logic [9:0]  a_waddr;
  logic [1:0]  a_rf_we, a_hi_we, a_lo_we, a_is_load;
  logic        stall_a;
  logic [1:0]  left_a;
  logic [15:0] cnt_a;

  logic [14:0] f_waddr;
  logic [2:0]  f_rf_we, f_hi_we, f_lo_we, f_is_load;
  logic        stall_f;
  logic [1:0]  left_f;
  logic [1:0]  cnt_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_stall_unit u_full (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd), .id_hi_rd(id_hi_rd), .id_lo_rd(id_lo_rd),
    .stg_waddr(a_waddr), .stg_rf_we(a_rf_we), .stg_hi_we(a_hi_we), .stg_lo_we(a_lo_we),
    .stg_is_load(a_is_load), .flush(flush),
    .stall(stall_a), .stall_left(left_a), .hazard_cnt(cnt_a)
  );

  hazard_stall_unit #(.AW(5), .N_STG(3), .FWD_EN(1), .PERF_W(2)) u_fwd (
    .clk(clk), .rst(rst_fwd), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd), .id_hi_rd(id_hi_rd), .id_lo_rd(id_lo_rd),
    .stg_waddr(f_waddr), .stg_rf_we(f_rf_we), .stg_hi_we(f_hi_we), .stg_lo_we(f_lo_we),
    .stg_is_load(f_is_load), .flush(flush),
    .stall(stall_f), .stall_left(left_f), .hazard_cnt(cnt_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge,
  // well away from the falling edge the DUT acts on.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs = '0; id_rt = '0;
    id_rs_rd = 1'b0; id_rt_rd = 1'b0; id_hi_rd = 1'b0; id_lo_rd = 1'b0;
    flush = 1'b0;
    a_waddr = '0; a_rf_we = '0; a_hi_we = '0; a_lo_we = '0; a_is_load = '0;
    f_waddr = '0; f_rf_we = '0; f_hi_we = '0; f_lo_we = '0; f_is_load = '0;
  endtask

  task automatic fwd_load_hazard();
    id_valid = 1'b1; id_rs = 5'd7; id_rs_rd = 1'b1;
    f_waddr = {5'd0, 5'd0, 5'd7}; f_rf_we = 3'b001; f_is_load = 3'b001;
  endtask

  initial begin
    idle();
    rst = 1'b1; rst_fwd = 1'b1;
    #3;
    check("rst_stall", 32'(stall_a), 0);
    check("rst_left", 32'(left_a), 0);
    check("rst_cnt", 32'(cnt_a), 0);
    check("rst_fwd_cnt", 32'(cnt_f), 0);
    step();
    rst = 1'b0; rst_fwd = 1'b0;
    step();
    check("idle_stall", 32'(stall_a), 0);

    // EXE hazard, full stall: 2 cycles
    id_valid = 1'b1; id_rs = 5'd3; id_rs_rd = 1'b1;
    a_waddr = {5'd0, 5'd3}; a_rf_we = 2'b01;
    step();
    check("exe_stall1", 32'(stall_a), 1);
    check("exe_left1", 32'(left_a), 1);
    check("exe_cnt", 32'(cnt_a), 1);
    step();
    check("exe_stall2", 32'(stall_a), 1);
    check("exe_left2", 32'(left_a), 0);
    check("exe_cnt_hold", 32'(cnt_a), 1);
    step();
    check("exe_release", 32'(stall_a), 0);
    idle();
    step();
    check("exe_after", 32'(stall_a), 0);

    // MEM hazard on rt: 1 cycle
    id_valid = 1'b1; id_rt = 5'd3; id_rt_rd = 1'b1;
    a_waddr = {5'd3, 5'd0}; a_rf_we = 2'b10;
    step();
    check("mem_stall", 32'(stall_a), 1);
    check("mem_left", 32'(left_a), 0);
    check("mem_cnt", 32'(cnt_a), 2);
    step();
    check("mem_release", 32'(stall_a), 0);
    idle();

    // Both stages match: one event, nearest wins (2 cycles)
    id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd4; id_rs_rd = 1'b1; id_rt_rd = 1'b1;
    a_waddr = {5'd3, 5'd4}; a_rf_we = 2'b11;
    step();
    check("dual_stall1", 32'(stall_a), 1);
    check("dual_left1", 32'(left_a), 1);
    check("dual_cnt", 32'(cnt_a), 3);
    step();
    check("dual_stall2", 32'(stall_a), 1);
    step();
    check("dual_release", 32'(stall_a), 0);
    idle();
    step();

    // $0 never hazards; unread source never hazards
    id_valid = 1'b1; id_rs = 5'd0; id_rs_rd = 1'b1;
    a_waddr = {5'd0, 5'd0}; a_rf_we = 2'b01;
    step();
    check("r0_stall", 32'(stall_a), 0);
    id_rs = 5'd3; id_rs_rd = 1'b0; a_waddr = {5'd0, 5'd3};
    step();
    check("noread_stall", 32'(stall_a), 0);
    check("noread_cnt", 32'(cnt_a), 3);
    idle();

    // HI in EXE: 2-cycle stall, cancelled by flush in the first cycle
    id_valid = 1'b1; id_hi_rd = 1'b1; a_hi_we = 2'b01;
    step();
    check("hi_stall", 32'(stall_a), 1);
    check("hi_left", 32'(left_a), 1);
    check("hi_cnt", 32'(cnt_a), 4);
    flush = 1'b1;
    step();
    check("flush_stall", 32'(stall_a), 0);
    check("flush_left", 32'(left_a), 0);
    idle();
    step();
    check("flush_after", 32'(stall_a), 0);

    // LO in MEM: 1-cycle stall
    id_valid = 1'b1; id_lo_rd = 1'b1; a_lo_we = 2'b10;
    step();
    check("lo_stall", 32'(stall_a), 1);
    check("lo_left", 32'(left_a), 0);
    check("lo_cnt", 32'(cnt_a), 5);
    idle();
    step();
    check("lo_release", 32'(stall_a), 0);

    // Bubble in ID, and flush in RUN, suppress detection
    id_rs = 5'd3; id_rs_rd = 1'b1; a_waddr = {5'd0, 5'd3}; a_rf_we = 2'b01;
    id_valid = 1'b0;
    step();
    check("bubble_stall", 32'(stall_a), 0);
    id_valid = 1'b1; flush = 1'b1;
    step();
    check("flushrun_stall", 32'(stall_a), 0);
    check("flushrun_cnt", 32'(cnt_a), 5);
    idle();

    // Async reset in the middle of a 2-cycle stall
    id_valid = 1'b1; id_rs = 5'd3; id_rs_rd = 1'b1;
    a_waddr = {5'd0, 5'd3}; a_rf_we = 2'b01;
    step();
    check("pre_rst_left", 32'(left_a), 1);
    idle();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_stall", 32'(stall_a), 0);
    check("rst_mid_left", 32'(left_a), 0);
    check("rst_mid_cnt", 32'(cnt_a), 0);
    check("fwd_untouched", 32'(cnt_f), 0);
    step();
    rst = 1'b0;

    // Forwarding instance: ALU result in EXE forwarded, no stall
    id_valid = 1'b1; id_rs = 5'd7; id_rs_rd = 1'b1;
    f_waddr = {5'd0, 5'd0, 5'd7}; f_rf_we = 3'b001; f_is_load = 3'b000;
    step();
    check("fwd_alu_stall", 32'(stall_f), 0);
    f_is_load = 3'b001;
    step();
    check("fwd_load_stall", 32'(stall_f), 1);
    check("fwd_load_left", 32'(left_f), 0);
    check("fwd_load_cnt", 32'(cnt_f), 1);
    idle();
    step();
    check("fwd_load_release", 32'(stall_f), 0);

    // Load further out, and HI producer, need no stall when forwarding
    id_valid = 1'b1; id_rs = 5'd7; id_rs_rd = 1'b1;
    f_waddr = {5'd0, 5'd7, 5'd0}; f_rf_we = 3'b010; f_is_load = 3'b010;
    step();
    check("fwd_far_load", 32'(stall_f), 0);
    idle();
    id_valid = 1'b1; id_hi_rd = 1'b1; f_hi_we = 3'b001; f_is_load = 3'b001;
    step();
    check("fwd_hi", 32'(stall_f), 0);
    idle();

    // Async reset mid-stall on the forwarding instance
    fwd_load_hazard();
    step();
    check("fwd_pre_rst", 32'(stall_f), 1);
    idle();
    #2 rst_fwd = 1'b1;
    #1;
    check("fwd_rst_stall", 32'(stall_f), 0);
    check("fwd_rst_left", 32'(left_f), 0);
    check("fwd_rst_cnt", 32'(cnt_f), 0);
    step();
    rst_fwd = 1'b0;
    step();

    // 2-bit event counter wraps 3 -> 0
    for (int i = 0; i < 4; i++) begin
      fwd_load_hazard();
      step();
      check("wrap_cnt", 32'(cnt_f), 32'((i + 1) % 4));
      idle();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
